// File: rtl/tone_arbiter_if.sv
// Request/tone bundle between the game controller side and tone_arbiter.
// The controller drives requests as master; the arbiter drives the tone-generator signals as slave.
interface tone_arbiter_if #(
  parameter int PERIOD_W = 16
);
  logic                btn_req;
  logic [1:0]          btn_color;
  logic                start_req;
  logic                win_req;
  logic                lose_req;
  logic [3:0]          grant;
  logic [PERIOD_W-1:0] tone_period;
  logic                tone_ena;
  logic                done;

  modport master (
    output btn_req, btn_color, start_req, win_req, lose_req,
    input  grant, tone_period, tone_ena, done
  );

  modport slave (
    input  btn_req, btn_color, start_req, win_req, lose_req,
    output grant, tone_period, tone_ena, done
  );
endinterface

// File: rtl/tone_arbiter.sv
// Fixed-priority owner of the speaker tone generator (lose > win > start > button) with a jingle ROM sequencer.
// Optional macro TONE_GAP_EN inserts GAP_TICKS silent cycles between consecutive jingle notes.
module tone_arbiter #(
  parameter int NOTE_TICKS = 1_250_000,
  parameter int GAP_TICKS  = 125_000,
  parameter int PERIOD_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  tone_arbiter_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_BTN, S_PLAY, S_GAP, S_FIN} state_t;

  localparam logic [1:0] J_START = 2'd0;
  localparam logic [1:0] J_WIN   = 2'd1;
  localparam logic [1:0] J_LOSE  = 2'd2;

  localparam int MAXT = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_TICKS - 1);
`ifdef TONE_GAP_EN
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
`endif

  function automatic logic [PERIOD_W-1:0] note_period(input logic [2:0] n);
    logic [PERIOD_W-1:0] p;
    case (n)
      3'd0:    p = PERIOD_W'(2389);
      3'd1:    p = PERIOD_W'(2128);
      3'd2:    p = PERIOD_W'(1896);
      3'd3:    p = PERIOD_W'(1790);
      3'd4:    p = PERIOD_W'(1594);
      3'd5:    p = PERIOD_W'(1420);
      3'd6:    p = PERIOD_W'(1265);
      default: p = PERIOD_W'(1194);
    endcase
    return p;
  endfunction

  function automatic logic [2:0] color_note(input logic [1:0] c);
    logic [2:0] n;
    case (c)
      2'd0:    n = 3'd0;
      2'd1:    n = 3'd2;
      2'd2:    n = 3'd4;
      default: n = 3'd7;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] rom_note(input logic [1:0] j, input logic [1:0] i);
    logic [2:0] n;
    case ({j, i})
      4'b0000: n = 3'd0;
      4'b0001: n = 3'd2;
      4'b0010: n = 3'd4;
      4'b0011: n = 3'd7;
      4'b0100, 4'b0101, 4'b0110, 4'b0111: n = 3'd7;
      4'b1000: n = 3'd3;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // {last note of jingle, duration in units}
  function automatic logic [3:0] rom_len(input logic [1:0] j, input logic [1:0] i);
    logic [3:0] l;
    case ({j, i})
      4'b0000, 4'b0001, 4'b0010: l = {1'b0, 3'd1};
      4'b0011:                   l = {1'b1, 3'd1};
      4'b0100, 4'b0101, 4'b0110: l = {1'b0, 3'd1};
      4'b0111:                   l = {1'b1, 3'd2};
      4'b1000:                   l = {1'b0, 3'd2};
      4'b1001:                   l = {1'b1, 3'd4};
      default:                   l = {1'b1, 3'd1};
    endcase
    return l;
  endfunction

  state_t              state_q;
  logic [2:0]          pend_q;
  logic [2:0]          pend_d;
  logic [2:0]          pend_clr;
  logic [3:0]          grant_q;
  logic [PERIOD_W-1:0] period_q;
  logic                ena_q;
  logic                done_q;
  logic [1:0]          jing_q;
  logic [1:0]          idx_q;
  logic [2:0]          units_q;
  logic [TW-1:0]       tick_q;

  logic [1:0]          sel_jing;
  logic                grant_now;
  logic                cur_last;
  logic [2:0]          cur_units;

  always_comb begin
    sel_jing = J_START;
    if (pend_q[J_LOSE]) begin
      sel_jing = J_LOSE;
    end else if (pend_q[J_WIN]) begin
      sel_jing = J_WIN;
    end
  end

  // A request arriving on the grant cycle survives the clear, so the jingle replays.
  assign grant_now = ((state_q == S_IDLE) || (state_q == S_BTN)) && (|pend_q);
  assign pend_clr  = grant_now ? (3'b001 << sel_jing) : 3'b000;
  assign pend_d    = (pend_q & ~pend_clr) | {bus.lose_req, bus.win_req, bus.start_req};

  assign {cur_last, cur_units} = rom_len(jing_q, idx_q);

`ifndef TONE_GAP_EN
  logic [1:0] idx_nxt;
  assign idx_nxt = idx_q + 2'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      grant_q  <= '0;
      period_q <= '0;
      ena_q    <= 1'b0;
      done_q   <= 1'b0;
      jing_q   <= J_START;
      idx_q    <= '0;
      units_q  <= '0;
      tick_q   <= '0;
    end else begin
      pend_q <= pend_d;
      done_q <= 1'b0;
      if (grant_now) begin
        state_q  <= S_PLAY;
        jing_q   <= sel_jing;
        idx_q    <= '0;
        units_q  <= '0;
        tick_q   <= '0;
        grant_q  <= 4'b0010 << sel_jing;
        ena_q    <= 1'b1;
        period_q <= note_period(rom_note(sel_jing, 2'd0));
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.btn_req) begin
              state_q <= S_BTN;
            end
          end
          S_BTN: begin
            if (bus.btn_req) begin
              grant_q  <= 4'b0001;
              ena_q    <= 1'b1;
              period_q <= note_period(color_note(bus.btn_color));
            end else begin
              state_q  <= S_IDLE;
              grant_q  <= '0;
              ena_q    <= 1'b0;
              period_q <= '0;
            end
          end
          S_PLAY: begin
            if (tick_q == NOTE_LAST) begin
              tick_q <= '0;
              if (units_q == cur_units - 3'd1) begin
                units_q <= '0;
                if (cur_last) begin
                  state_q  <= S_FIN;
                  done_q   <= 1'b1;
                  grant_q  <= '0;
                  ena_q    <= 1'b0;
                  period_q <= '0;
                end else begin
                  idx_q <= idx_q + 2'd1;
`ifdef TONE_GAP_EN
                  state_q <= S_GAP;
                  ena_q   <= 1'b0;
`else
                  period_q <= note_period(rom_note(jing_q, idx_nxt));
`endif
                end
              end else begin
                units_q <= units_q + 3'd1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
`ifdef TONE_GAP_EN
          S_GAP: begin
            if (tick_q == GAP_LAST) begin
              tick_q   <= '0;
              state_q  <= S_PLAY;
              ena_q    <= 1'b1;
              period_q <= note_period(rom_note(jing_q, idx_q));
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
`endif
          S_FIN:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.tone_period = period_q;
  assign bus.tone_ena    = ena_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with NOTE_TICKS=4 and GAP_TICKS=2; expects gaps when TONE_GAP_EN is defined.
module tb_tone_arbiter;
  localparam int PW = 16;
  localparam int NT = 4;
  localparam int GT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tone_arbiter_if #(.PERIOD_W(PW)) bus ();

  tone_arbiter #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .PERIOD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_n;
  int exp_p [4];
  int exp_u [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Packed view {done, grant, ena, period}
  function automatic logic [31:0] obs();
    return {10'b0, bus.done, bus.grant, bus.tone_ena, bus.tone_period};
  endfunction

  function automatic logic [31:0] ev(input logic d, input logic [3:0] g, input logic e, input int p);
    return {10'b0, d, g, e, p[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_jingle(input int j);
    case (j)
      0: begin exp_n = 4; exp_p = '{2389, 1896, 1594, 1194}; exp_u = '{1, 1, 1, 1}; end
      1: begin exp_n = 4; exp_p = '{1194, 1194, 1194, 1194}; exp_u = '{1, 1, 1, 2}; end
      default: begin exp_n = 2; exp_p = '{1790, 2389, 0, 0}; exp_u = '{2, 4, 0, 0}; end
    endcase
  endtask

  // Called on the first cycle of a jingle; returns on the idle cycle after DONE.
  // poke >= 0 raises lose_req for one cycle at that cycle offset.
  task automatic play_check(input string tag, input logic [3:0] g, input int poke);
    int cyc = 0;
    for (int k = 0; k < exp_n; k++) begin
      for (int c = 0; c < exp_u[k] * NT; c++) begin
        bus.lose_req = (cyc == poke);
        check_eq(tag, obs(), ev(1'b0, g, 1'b1, exp_p[k]));
        step();
        cyc++;
      end
`ifdef TONE_GAP_EN
      if (k < exp_n - 1) begin
        for (int c = 0; c < GT; c++) begin
          bus.lose_req = (cyc == poke);
          check_eq({tag, "_gap"}, obs(), ev(1'b0, g, 1'b0, exp_p[k]));
          step();
          cyc++;
        end
      end
`endif
    end
    bus.lose_req = 1'b0;
    check_eq({tag, "_done"}, obs(), ev(1'b1, 4'b0000, 1'b0, 0));
    step();
    check_eq({tag, "_idle"}, obs(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_req   = 1'b0;
    bus.btn_color = 2'd0;
    bus.start_req = 1'b0;
    bus.win_req   = 1'b0;
    bus.lose_req  = 1'b0;
    step();
    step();
    check_eq("reset_out", obs(), 32'h0);
    rst = 1'b0;
    step();
    check_eq("post_reset_idle", obs(), 32'h0);
    $display("[TB] reset state checked");

    bus.start_req = 1'b1;
    step();
    bus.start_req = 1'b0;
    check_eq("start_t1", obs(), 32'h0);
    step();
    set_jingle(0);
    play_check("start", 4'b0010, -1);
    $display("[TB] start jingle checked");

    step();
    bus.btn_req   = 1'b1;
    bus.btn_color = 2'd2;
    step();
    check_eq("btn_t1", obs(), 32'h0);
    step();
    check_eq("btn_c2", obs(), ev(1'b0, 4'b0001, 1'b1, 1594));
    bus.btn_color = 2'd3;
    step();
    check_eq("btn_c3", obs(), ev(1'b0, 4'b0001, 1'b1, 1194));
    bus.btn_req = 1'b0;
    step();
    check_eq("btn_rel", obs(), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("btn_nodone", obs(), 32'h0);
    end
    $display("[TB] button tone checked");

    bus.btn_color = 2'd0;
    bus.btn_req   = 1'b1;
    step();
    step();
    check_eq("btn_c0", obs(), ev(1'b0, 4'b0001, 1'b1, 2389));
    bus.lose_req = 1'b1;
    step();
    bus.lose_req = 1'b0;
    check_eq("preempt_hold", obs(), ev(1'b0, 4'b0001, 1'b1, 2389));
    step();
    set_jingle(2);
    play_check("lose_pre", 4'b1000, -1);
    step();
    check_eq("btn_resume_wait", obs(), 32'h0);
    step();
    check_eq("btn_resume", obs(), ev(1'b0, 4'b0001, 1'b1, 2389));
    bus.btn_req = 1'b0;
    step();
    check_eq("btn_rel2", obs(), 32'h0);
    $display("[TB] lose preempting button checked");

    step();
    bus.win_req   = 1'b1;
    bus.start_req = 1'b1;
    step();
    bus.win_req   = 1'b0;
    bus.start_req = 1'b0;
    step();
    set_jingle(1);
    play_check("win", 4'b0100, -1);
    step();
    set_jingle(0);
    play_check("start2", 4'b0010, -1);
    $display("[TB] win then start checked");

    step();
    bus.lose_req = 1'b1;
    step();
    bus.lose_req = 1'b0;
    step();
    set_jingle(2);
    play_check("lose1", 4'b1000, 10);
    step();
    play_check("lose2", 4'b1000, -1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("no_third_lose", obs(), 32'h0);
    end
    $display("[TB] lose replay checked");

    // Second start pulse lands on the grant cycle, so the start jingle plays twice.
    bus.start_req = 1'b1;
    step();
    step();
    bus.start_req = 1'b0;
    set_jingle(0);
    play_check("start_a", 4'b0010, -1);
    step();
    play_check("start_b", 4'b0010, -1);
    step();
    check_eq("start_no_third", obs(), 32'h0);
    $display("[TB] set-over-clear replay checked");

    bus.win_req = 1'b1;
    step();
    bus.win_req = 1'b0;
    step();
    check_eq("win_run", obs(), ev(1'b0, 4'b0100, 1'b1, 1194));
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    check_eq("async_rst", obs(), 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("no_resume", obs(), 32'h0);
    end
    $display("[TB] reset mid-jingle checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
